// File: rtl/repk_frm_buf.sv
// repk_frm_buf
// Frame buffer behind the repacker. Words inside a repk_frm envelope go into a
// circular data store at a speculative write pointer. When the frame closes,
// the frame is committed: its word count goes into a small length store.
// Frames that cannot be held are dropped whole. These are frames that arrive
// with no free length slot, or frames that overflow the data store. The
// reader opens the head frame with rd_start and pulls its words with rd_en.
//
// Parameters
//   ADDR_W    : data store holds 2^ADDR_W 16-bit words
//   LEN_DEPTH : number of committed frames the length store can hold
//   INT_TH    : committed-frame count at which frm_int_n goes low
//
// Ports
//   clk_sys   in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   repk_data in  16  repacker word
//   repk_vld  in   1  word strobe
//   repk_frm  in   1  frame envelope
//   rd_start  in   1  open head frame for reading (pulse)
//   rd_en     in   1  read one word of the open frame
//   rd_data   out 16  read word, one cycle after rd_en
//   rd_vld    out  1  rd_data valid pulse
//   frm_len   out 16  word count of head committed frame, 0 if none
//   frm_cnt   out  4  committed, unopened frames
//   frm_int_n out  1  low while frm_cnt >= INT_TH
//   drop_cnt  out  8  dropped frames, saturating
//
// Build option: define REPK_FRM_BUF_STAT_EN to implement drop_cnt. Without
// it, drop_cnt is tied to 0.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for a repk_frm rising edge
//   W_FRM  | storing words of an accepted frame
//   W_DROP | discarding the rest of a rejected frame
// Read FSM
//   state  | meaning
//   R_IDLE | no frame open
//   R_BUSY | head frame open, words remaining
module repk_frm_buf #(
    parameter int ADDR_W    = 10,
    parameter int LEN_DEPTH = 8,
    parameter int INT_TH    = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] repk_data,
    input  logic        repk_vld,
    input  logic        repk_frm,
    input  logic        rd_start,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_vld,
    output logic [15:0] frm_len,
    output logic [3:0]  frm_cnt,
    output logic        frm_int_n,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(LEN_DEPTH + 1);
    localparam int LEN_AW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  LEN_MAX  = CNT_W'(LEN_DEPTH);
    localparam logic [CNT_W-1:0]  INT_LVL  = CNT_W'(INT_TH);
    localparam logic [LEN_AW-1:0] LEN_LAST = LEN_AW'(LEN_DEPTH - 1);

    typedef enum logic [1:0] {W_IDLE, W_FRM, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_BUSY} r_state_t;

    w_state_t           w_state_q, w_state_d;
    r_state_t           r_state_q, r_state_d;
    logic               frm_prev_q;
    logic [PTR_W-1:0]   wspec_q, wspec_d;
    logic [PTR_W-1:0]   wcom_q, wcom_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [15:0]        wcnt_q, wcnt_d;
    logic [LEN_AW-1:0]  len_wp_q, len_wp_d;
    logic [LEN_AW-1:0]  len_rp_q, len_rp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        rem_q, rem_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_vld_q, rd_vld_d;
    logic               int_n_q, int_n_d;

    logic [15:0]        mem [DEPTH];
    logic [15:0]        len_mem [LEN_DEPTH];

    logic               frm_rise, frm_fall, word_in, take_word, st_full;
    logic               mem_we, push, pop, rd_fire;
    logic [PTR_W-1:0]   occ;

    // frm_prev_q resets high so that a frame already running at reset
    // release shows no rising edge and is skipped until repk_frm drops.
    assign frm_rise = repk_frm & ~frm_prev_q;
    assign frm_fall = ~repk_frm & frm_prev_q;
    assign word_in  = repk_vld & repk_frm;
    // Occupancy never exceeds DEPTH, so its MSB alone flags a full store.
    assign occ      = wspec_q - rptr_q;
    assign st_full  = occ[ADDR_W];

    always_comb begin
        w_state_d = w_state_q;
        wspec_d   = wspec_q;
        wcom_d    = wcom_q;
        wcnt_d    = wcnt_q;
        take_word = 1'b0;
        mem_we    = 1'b0;
        push      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (frm_rise) begin
                    if (cnt_q < LEN_MAX) begin
                        w_state_d = W_FRM;
                        wcnt_d    = '0;
                        take_word = word_in;
                    end else begin
                        w_state_d = W_DROP;
                    end
                end
            end
            W_FRM: begin
                if (frm_fall) begin
                    if (wcnt_q != '0) begin
                        push   = 1'b1;
                        wcom_d = wspec_q;
                    end
                    wcnt_d    = '0;
                    w_state_d = W_IDLE;
                end else begin
                    take_word = word_in;
                end
            end
            W_DROP: begin
                if (frm_fall) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        // An overflowing word throws away the whole frame. The speculative
        // pointer falls back to the last commit point.
        if (take_word) begin
            if (st_full) begin
                wspec_d   = wcom_q;
                wcnt_d    = '0;
                w_state_d = W_DROP;
            end else begin
                mem_we  = 1'b1;
                wspec_d = wspec_q + PTR_W'(1);
                wcnt_d  = wcnt_d + 16'd1;
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rem_d     = rem_q;
        pop       = 1'b0;
        rd_fire   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rd_start && cnt_q != '0) begin
                    pop       = 1'b1;
                    rem_d     = len_mem[len_rp_q];
                    r_state_d = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rd_en && rem_q != '0) begin
                    rd_fire = 1'b1;
                    rem_d   = rem_q - 16'd1;
                end
                if (rem_d == '0) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase

        rptr_d    = rptr_q + PTR_W'(rd_fire);
        rd_vld_d  = rd_fire;
        rd_data_d = rd_fire ? mem[rptr_q[ADDR_W-1:0]] : rd_data_q;
    end

    always_comb begin
        len_wp_d = len_wp_q;
        len_rp_d = len_rp_q;
        cnt_d    = cnt_q;
        if (push) len_wp_d = (len_wp_q == LEN_LAST) ? '0 : len_wp_q + LEN_AW'(1);
        if (pop)  len_rp_d = (len_rp_q == LEN_LAST) ? '0 : len_rp_q + LEN_AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        int_n_d = !(cnt_d >= INT_LVL);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            frm_prev_q <= 1'b1;
            wspec_q    <= '0;
            wcom_q     <= '0;
            rptr_q     <= '0;
            wcnt_q     <= '0;
            len_wp_q   <= '0;
            len_rp_q   <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            int_n_q    <= 1'b1;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            frm_prev_q <= repk_frm;
            wspec_q    <= wspec_d;
            wcom_q     <= wcom_d;
            rptr_q     <= rptr_d;
            wcnt_q     <= wcnt_d;
            len_wp_q   <= len_wp_d;
            len_rp_q   <= len_rp_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            int_n_q    <= int_n_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (mem_we) mem[wspec_q[ADDR_W-1:0]] <= repk_data;
        if (push)   len_mem[len_wp_q] <= wcnt_q;
    end

`ifdef REPK_FRM_BUF_STAT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_entry;

    always_comb begin
        drop_entry = (w_state_q != W_DROP) && (w_state_d == W_DROP);
        drop_cnt_d = drop_cnt_q;
        if (drop_entry && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

    assign rd_data   = rd_data_q;
    assign rd_vld    = rd_vld_q;
    assign frm_len   = (cnt_q != '0) ? len_mem[len_rp_q] : 16'h0000;
    assign frm_cnt   = 4'(cnt_q);
    assign frm_int_n = int_n_q;

endmodule

// File: tb/tb_repk_frm_buf.sv
module tb_repk_frm_buf;

`ifdef REPK_FRM_BUF_STAT_EN
    localparam logic [7:0] D1 = 8'd1;
`else
    localparam logic [7:0] D1 = 8'd0;
`endif

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst_n, repk_vld, repk_frm, rd_start, rd_en;
    logic [15:0] repk_data;

    logic [15:0] rd_data, frm_len, s_rd_data, s_frm_len;
    logic        rd_vld, frm_int_n, s_rd_vld, s_frm_int_n;
    logic [3:0]  frm_cnt, s_frm_cnt;
    logic [7:0]  drop_cnt, s_drop_cnt;

    repk_frm_buf #(.ADDR_W(10), .LEN_DEPTH(8), .INT_TH(1)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .repk_data(repk_data),
        .repk_vld(repk_vld), .repk_frm(repk_frm), .rd_start(rd_start),
        .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld), .frm_len(frm_len),
        .frm_cnt(frm_cnt), .frm_int_n(frm_int_n), .drop_cnt(drop_cnt)
    );

    repk_frm_buf #(.ADDR_W(4), .LEN_DEPTH(8), .INT_TH(1)) dut_s (
        .clk_sys(clk_sys), .rst_n(rst_n), .repk_data(repk_data),
        .repk_vld(repk_vld), .repk_frm(repk_frm), .rd_start(rd_start),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_vld(s_rd_vld), .frm_len(s_frm_len),
        .frm_cnt(s_frm_cnt), .frm_int_n(s_frm_int_n), .drop_cnt(s_drop_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mdl_data[$];
    int          mdl_len[$];
    bit          sel_small = 1'b0;
    bit          rd_exp = 1'b0;
    bit          en_p = 1'b0;
    bit          exp_vld = 1'b0;
    logic        m_vld;
    logic [15:0] m_data;

    assign m_vld  = sel_small ? s_rd_vld  : rd_vld;
    assign m_data = sel_small ? s_rd_data : rd_data;

    typedef struct {
        bit          is_rd;
        int          n;
        logic [15:0] base;
        bit          commit;
        logic [3:0]  cnt;
        logic [15:0] len;
        logic        int_n;
        logic [7:0]  drop;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Read scoreboard: rd_vld must follow each accepted rd_en by one cycle,
    // and each valid word must match the head of the expected queue.
    always @(posedge clk_sys) begin
        en_p    <= rd_en;
        exp_vld <= rd_exp;
    end

    always @(negedge clk_sys) begin
        if (rst_n && (en_p || m_vld)) begin
            chk("rd_vld", 32'(m_vld), 32'(exp_vld));
            if (m_vld) begin
                if (sb_q.size() == 0) chk("rd_extra_word", 32'(m_data), 32'hFFFF_FFFF);
                else                  chk("rd_data", 32'(m_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repk_vld = 1'b0; repk_frm = 1'b0; repk_data = '0;
        rd_start = 1'b0; rd_en = 1'b0; rd_exp = 1'b0;
        mdl_data.delete(); mdl_len.delete(); sb_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wr_frame(input int n, input logic [15:0] base, input bit commit);
        repk_vld = 1'b1; repk_data = 16'hDEAD;   // stray word outside envelope
        tick();
        repk_vld = 1'b0; repk_frm = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            repk_vld = 1'b1; repk_data = base + 16'(i);
            tick();
        end
        repk_vld = 1'b0; repk_frm = 1'b0;
        tick(3);
        if (commit) begin
            mdl_len.push_back(n);
            for (int i = 0; i < n; i++) mdl_data.push_back(base + 16'(i));
        end
    endtask

    task automatic rd_words(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1; rd_exp = 1'b1;
            sb_q.push_back(mdl_data.pop_front());
            tick();
        end
        rd_exp = 1'b0;   // one more rd_en after the frame must be ignored
        tick();
        rd_en = 1'b0;
        tick(2);
    endtask

    task automatic rd_frame();
        int n;
        n = (mdl_len.size() != 0) ? mdl_len.pop_front() : 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_words(n);
    endtask

    task automatic chk_big(input string tag, input logic [3:0] c, input logic [15:0] l,
                           input logic in, input logic [7:0] d);
        chk({tag, "_frm_cnt"},   32'(frm_cnt),   32'(c));
        chk({tag, "_frm_len"},   32'(frm_len),   32'(l));
        chk({tag, "_frm_int_n"}, 32'(frm_int_n), 32'(in));
        chk({tag, "_drop_cnt"},  32'(drop_cnt),  32'(d));
    endtask

    initial begin
        // ---- vector table on the default-size instance ----
        tbl[0]  = '{1'b0, 5, 16'h0001, 1'b1, 4'd1, 16'd5, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 0, 16'h0000, 1'b0, 4'd0, 16'd0, 1'b1, 8'd0};
        tbl[2]  = '{1'b0, 0, 16'h0000, 1'b0, 4'd0, 16'd0, 1'b1, 8'd0};
        for (int i = 3; i <= 10; i++)
            tbl[i] = '{1'b0, 3, 16'h0100 + 16'(16 * (i - 3)), 1'b1, 4'(i - 2), 16'd3, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 3, 16'h0900, 1'b0, 4'd8, 16'd3, 1'b0, D1};
        tbl[12] = '{1'b1, 0, 16'h0000, 1'b0, 4'd7, 16'd3, 1'b0, D1};
        tbl[13] = '{1'b0, 2, 16'h0A00, 1'b1, 4'd8, 16'd3, 1'b0, D1};
        for (int i = 14; i <= 19; i++)
            tbl[i] = '{1'b1, 0, 16'h0000, 1'b0, 4'(21 - i), 16'd3, 1'b0, D1};
        tbl[20] = '{1'b1, 0, 16'h0000, 1'b0, 4'd1, 16'd2, 1'b0, D1};
        tbl[21] = '{1'b1, 0, 16'h0000, 1'b0, 4'd0, 16'd0, 1'b1, D1};

        do_reset();
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_vld",  32'(rd_vld),  32'h0);
        chk_big("rst", 4'd0, 16'd0, 1'b1, 8'd0);
        chk("rst_s_frm_int_n", 32'(s_frm_int_n), 32'h1);

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].is_rd) rd_frame();
            else              wr_frame(tbl[i].n, tbl[i].base, tbl[i].commit);
            chk_big($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].len, tbl[i].int_n, tbl[i].drop);
        end

        // rd_start and rd_en with nothing committed
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        rd_en = 1'b1; tick(2); rd_en = 1'b0; tick(2);
        chk("empty_start_cnt", 32'(frm_cnt), 32'h0);

        // ---- small store: overflow drop at word 17, exact fit at 16 ----
        do_reset();
        sel_small = 1'b1;
        wr_frame(20, 16'h2000, 1'b0);
        chk("ovf20_cnt",  32'(s_frm_cnt),  32'h0);
        chk("ovf20_len",  32'(s_frm_len),  32'h0);
        chk("ovf20_drop", 32'(s_drop_cnt), 32'(D1));
        wr_frame(4, 16'h3000, 1'b1);
        chk("after_ovf_len", 32'(s_frm_len), 32'd4);
        chk("after_ovf_cnt", 32'(s_frm_cnt), 32'd1);
        rd_frame();
        wr_frame(16, 16'h4000, 1'b1);
        chk("fit16_len", 32'(s_frm_len), 32'd16);
        rd_frame();
        chk("fit16_cnt", 32'(s_frm_cnt), 32'd0);
        wr_frame(17, 16'h4800, 1'b0);
        chk("ovf17_cnt",  32'(s_frm_cnt),  32'h0);
        chk("ovf17_drop", 32'(s_drop_cnt), 32'(D1 * 8'd2));
        wr_frame(4, 16'h5000, 1'b1);
        rd_frame();
        chk("small_end_cnt", 32'(s_frm_cnt), 32'd0);
        sel_small = 1'b0;

        // ---- commit of B coincides with rd_start of A ----
        do_reset();
        wr_frame(3, 16'h5A00, 1'b1);
        chk("pre_same_len", 32'(frm_len), 32'd3);
        repk_frm = 1'b1; tick();
        repk_vld = 1'b1; repk_data = 16'h6000; tick();
        repk_data = 16'h6001; tick();
        repk_vld = 1'b0; repk_frm = 1'b0; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        mdl_len.push_back(2); mdl_data.push_back(16'h6000); mdl_data.push_back(16'h6001);
        chk("same_cycle_cnt", 32'(frm_cnt), 32'd1);
        chk("same_cycle_len", 32'(frm_len), 32'd2);
        rd_start = 1'b1; tick(); rd_start = 1'b0;   // busy: must be ignored
        chk("busy_start_cnt", 32'(frm_cnt), 32'd1);
        rd_words(mdl_len.pop_front());
        rd_frame();
        chk_big("same_cycle_end", 4'd0, 16'd0, 1'b1, 8'd0);

        // ---- reset mid-frame and during R_BUSY ----
        do_reset();
        wr_frame(3, 16'h7000, 1'b1);
        wr_frame(9, 16'h7100, 1'b1);
        void'(mdl_len.pop_front());
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        rd_en = 1'b1; rd_exp = 1'b1; sb_q.push_back(mdl_data.pop_front()); tick();
        rd_en = 1'b0; rd_exp = 1'b0; tick(2);
        repk_frm = 1'b1; tick();
        repk_vld = 1'b1; repk_data = 16'h7F00; tick();
        repk_data = 16'h7F01; tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_rd_data", 32'(rd_data), 32'h0);
        chk("midrst_rd_vld",  32'(rd_vld),  32'h0);
        chk_big("midrst", 4'd0, 16'd0, 1'b1, 8'd0);
        mdl_data.delete(); mdl_len.delete();
        tick();
        rst_n = 1'b1;
        repk_data = 16'h7F02; tick();
        repk_data = 16'h7F03; tick();
        repk_vld = 1'b0; repk_frm = 1'b0; tick(3);
        chk_big("post_rst", 4'd0, 16'd0, 1'b1, 8'd0);
        rd_en = 1'b1; tick(2); rd_en = 1'b0; tick(2);
        wr_frame(4, 16'h8000, 1'b1);
        chk("post_rst_len", 32'(frm_len), 32'd4);
        chk("post_rst_cnt", 32'(frm_cnt), 32'd1);
        rd_frame();
        chk_big("final", 4'd0, 16'd0, 1'b1, 8'd0);

        tick(2);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/repk_frm_buf.md
REPK_FRM_BUF -- requirements
Module: repk_frm_buf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, setting the data store depth to 2^ADDR_W 16-bit words.
REQ-002 The block SHALL have parameter LEN_DEPTH, default 8, setting the number of committed frames held.
REQ-003 The block SHALL have parameter INT_TH, default 1, the committed-frame count at which frm_int_n asserts.
REQ-004 Port clk_sys, input, 1: the single system clock; every flop SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port repk_data, input, 16: repacker word, sampled when repk_vld=1.
REQ-007 Port repk_vld, input, 1: word strobe, one word per high cycle.
REQ-008 Port repk_frm, input, 1: frame envelope, high for the whole frame.
REQ-009 Port rd_start, input, 1: one-cycle pulse that opens the head frame for reading.
REQ-010 Port rd_en, input, 1: read one word of the open frame.
REQ-011 Port rd_data, output, 16: read word.
REQ-012 Port rd_vld, output, 1: rd_data valid.
REQ-013 Port frm_len, output, 16: word count of the head committed frame; 0 when no frame is committed.
REQ-014 Port frm_cnt, output, 4: number of committed, unopened frames.
REQ-015 Port frm_int_n, output, 1: active-low interrupt, low while frm_cnt >= INT_TH.
REQ-016 Port drop_cnt, output, 8: dropped-frame counter (see Configuration).

Function
REQ-017 Write FSM SHALL have states W_IDLE, W_FRM and W_DROP.
REQ-018 W_IDLE->W_FRM on a repk_frm rising edge when the length store has a free slot; otherwise W_IDLE->W_DROP.
REQ-019 In W_FRM each repk_vld word SHALL be written at the speculative write pointer, and a frame word count SHALL be incremented.
REQ-020 If a word arrives in W_FRM while the store is full (free space = 2^ADDR_W - (wptr - rptr) = 0), the speculative pointer SHALL rewind to the frame start and the FSM SHALL enter W_DROP.
REQ-021 On a repk_frm falling edge in W_FRM with word count > 0: commit pointer <= speculative pointer, count pushed to length store, frm_cnt +1, return to W_IDLE.
REQ-022 A frame with zero words SHALL be discarded silently: not counted, not dropped.
REQ-023 W_DROP SHALL ignore all words and return to W_IDLE on the repk_frm falling edge; each W_DROP entry is one drop.
REQ-024 A repk_vld outside repk_frm SHALL be ignored.
REQ-025 Read FSM SHALL have states R_IDLE and R_BUSY; rd_start in R_IDLE with frm_cnt > 0 pops the head length into a remaining counter, decrements frm_cnt, and enters R_BUSY.
REQ-026 rd_start in R_BUSY or with frm_cnt = 0 SHALL be ignored.
REQ-027 In R_BUSY, rd_en SHALL read the word at rptr, advance rptr, and decrement remaining; rd_data/rd_vld follow rd_en with exactly one cycle latency; rd_vld is a single-cycle pulse per word.
REQ-028 rd_en in R_IDLE or with remaining = 0 SHALL be ignored (rd_vld stays 0); remaining reaching 0 returns the FSM to R_IDLE.
REQ-029 Read-side space SHALL be freed per word read, not per frame.
REQ-030 A commit and a pop in the same cycle SHALL leave frm_cnt unchanged.
REQ-031 Pointers SHALL be ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).

Reset
REQ-032 On rst_n low, all pointers, counters, FSMs (W_IDLE, R_IDLE), rd_data=0, rd_vld=0, frm_len=0, frm_cnt=0, drop_cnt=0, and frm_int_n=1 SHALL be set asynchronously.
REQ-033 After release, a frame already in progress (repk_frm high at release) SHALL be ignored until repk_frm falls.

Configuration
REQ-034 With macro REPK_FRM_BUF_STAT_EN defined, drop_cnt SHALL increment on each W_DROP entry, saturating at 255.
REQ-035 Without REPK_FRM_BUF_STAT_EN, drop_cnt SHALL be constant 0, and no counter logic SHALL be synthesised.

Verification
REQ-036 Frame of 5 words 0x0001..0x0005, then rd_start and 5 rd_en -> frm_len=5, frm_cnt 1->0, rd_data 0x0001..0x0005 one cycle after each rd_en, frm_int_n 0->1.
REQ-037 Nine 3-word frames, none read -> frm_cnt=8; ninth frame dropped; drop_cnt=1 with the macro, 0 without.
REQ-038 ADDR_W=4, 20-word frame -> dropped at word 17, frm_cnt=0, write pointer restored, a following 4-word frame reads back intact.
REQ-039 Commit of frame B in the same cycle as rd_start of frame A -> frm_cnt unchanged, frm_len switches to B's length.
REQ-040 rst_n pulsed low mid-frame and during R_BUSY -> all outputs at reset values; the remainder of the interrupted frame is ignored; the next frame buffers normally.
